// File: rtl/mant_div_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mant_div_datapath_pkg
// Brief    : Shared widths for the FP32 mantissa divide/round path.
// Revision : 1.0 - initial release
// ============================================================================
package mant_div_datapath_pkg;

    localparam int MANT_W = 24;
    localparam int QUOT_W = 24;
    localparam int CNT_W  = 5;

endpackage : mant_div_datapath_pkg
`default_nettype wire

// File: rtl/mant_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mant_div_step
// Brief    : One restoring-division iteration: compare, conditional subtract,
//            shift left by one.
// Revision : 1.0 - initial release
// ============================================================================
module mant_div_step #(
    parameter int W = 24
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_rem_next,
    output logic         o_q
);

    logic [W:0] w_div_ext;
    logic [W:0] w_diff;
    logic [W:0] w_sel;

    assign w_div_ext  = {1'b0, i_div};
    assign w_diff     = i_rem - w_div_ext;
    assign o_q        = (i_rem >= w_div_ext);
    // The remainder stays below 2*D, so its top bit is always free to drop.
    assign w_sel      = o_q ? w_diff : i_rem;
    assign o_rem_next = w_sel << 1;

endmodule : mant_div_step
`default_nettype wire

// File: rtl/mant_div_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mant_div_datapath
// Brief    : Restoring one-bit-per-cycle mantissa divider datapath producing
//            quotient and sticky bit for the normalise/round stage.
// Revision : 1.0 - initial release
// ============================================================================
module mant_div_datapath
    import mant_div_datapath_pkg::*;
#(
    parameter int W  = MANT_W,
    parameter int N  = QUOT_W,
    parameter int CW = CNT_W
) (
    input  logic         in_Clk,
    input  logic         in_Rst,
    input  logic         in_load,
    input  logic         in_shift_en,
    input  logic [W-1:0] in_dividend,
    input  logic [W-1:0] in_divisor,
    output logic [N-1:0] out_quotient,
    output logic         out_sticky,
    output logic         out_done,
    output logic         out_busy
);

    localparam logic [CW-1:0] c_cnt_max = CW'(N);

    logic [W:0]    r_rem;
    logic [W-1:0]  r_div;
    logic [N-1:0]  r_quot;
    logic [CW-1:0] r_cnt;
    logic          r_loaded;

    logic [W:0]    w_rem_next;
    logic          w_q;
    logic          w_running;
    logic          w_iterate;

    mant_div_step #(
        .W (W)
    ) u_step (
        .i_rem      (r_rem),
        .i_div      (r_div),
        .o_rem_next (w_rem_next),
        .o_q        (w_q)
    );

    assign w_running = r_loaded && (r_cnt < c_cnt_max);
    assign w_iterate = in_shift_en && w_running;

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_rem    <= '0;
            r_div    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
        end else if (in_load) begin
            // A load always restarts, even mid-division, and never iterates.
            r_rem    <= {1'b0, in_dividend};
            r_div    <= in_divisor;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_loaded <= 1'b1;
        end else if (w_iterate) begin
            r_rem    <= w_rem_next;
            r_quot   <= {r_quot[N-2:0], w_q};
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign out_quotient = r_quot;
    assign out_sticky   = |r_rem;
    assign out_busy     = w_running;
    assign out_done     = r_loaded && (r_cnt == c_cnt_max);

endmodule : mant_div_datapath
`default_nettype wire

// File: tb/tb_mant_div_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mant_div_datapath
// Brief    : Directed, table-driven self-checking bench for mant_div_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mant_div_datapath;

    localparam int W = 24;
    localparam int N = 24;

    logic         clk;
    logic         rst;
    logic         load;
    logic         shift_en;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [N-1:0] quotient;
    logic         sticky;
    logic         done;
    logic         busy;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [N-1:0] exp_q;
        logic         exp_s;
    } vec_t;

    vec_t vecs [8];

    mant_div_datapath dut (
        .in_Clk       (clk),
        .in_Rst       (rst),
        .in_load      (load),
        .in_shift_en  (shift_en),
        .in_dividend  (dividend),
        .in_divisor   (divisor),
        .out_quotient (quotient),
        .out_sticky   (sticky),
        .out_done     (done),
        .out_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b, input logic sh);
        dividend = a;
        divisor  = b;
        load     = 1'b1;
        shift_en = sh;
        tick();
        load     = 1'b0;
        shift_en = 1'b0;
    endtask

    task automatic do_shift(input int n);
        shift_en = 1'b1;
        for (int k = 0; k < n; k++) tick();
        shift_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        load     = 1'b0;
        shift_en = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{24'h800000, 24'h800000, 24'h800000, 1'b0};
        vecs[1] = '{24'hC00000, 24'h800000, 24'hC00000, 1'b0};
        vecs[2] = '{24'h800000, 24'hC00000, 24'h555555, 1'b1};
        vecs[3] = '{24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0};
        vecs[4] = '{24'h800000, 24'hFFFFFF, 24'h400000, 1'b1};
        vecs[5] = '{24'hA00000, 24'h800000, 24'hA00000, 1'b0};
        vecs[6] = '{24'hC00000, 24'hC00000, 24'h800000, 1'b0};
        vecs[7] = '{24'h800000, 24'h000000, 24'hFFFFFF, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        check("reset_quotient", 32'(quotient), 32'h0);
        check("reset_sticky",   32'(sticky),   32'h0);
        check("reset_done",     32'(done),     32'h0);
        check("reset_busy",     32'(busy),     32'h0);

        // Shift strobes before any load must be ignored.
        do_shift(3);
        check("idle_shift_busy", 32'(busy), 32'h0);
        check("idle_shift_done", 32'(done), 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("v%0d_load_busy", i), 32'(busy), 32'h1);
            check($sformatf("v%0d_load_done", i), 32'(done), 32'h0);
            check($sformatf("v%0d_load_q",    i), 32'(quotient), 32'h0);
            do_shift(N - 1);
            check($sformatf("v%0d_n1_done", i), 32'(done), 32'h0);
            do_shift(1);
            check($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].exp_q));
            check($sformatf("v%0d_sticky",   i), 32'(sticky),   32'(vecs[i].exp_s));
            check($sformatf("v%0d_done",     i), 32'(done),     32'h1);
            check($sformatf("v%0d_busy",     i), 32'(busy),     32'h0);
        end

        // Load with shift_en high: no iteration on the load edge, then saturate.
        do_load(24'h800000, 24'hC00000, 1'b1);
        check("ls_load_busy", 32'(busy), 32'h1);
        do_shift(2);
        check("ls_q_after2", 32'(quotient), 32'h1);
        do_shift(N - 3);
        check("ls_n1_done", 32'(done), 32'h0);
        do_shift(1);
        check("ls_done", 32'(done), 32'h1);
        do_shift(6);
        check("ls_sat_done",     32'(done),     32'h1);
        check("ls_sat_busy",     32'(busy),     32'h0);
        check("ls_sat_quotient", 32'(quotient), 32'h555555);
        check("ls_sat_sticky",   32'(sticky),   32'h1);

        // Restart mid-division.
        do_load(24'h800000, 24'hC00000, 1'b0);
        do_shift(10);
        check("rs_mid_busy", 32'(busy), 32'h1);
        do_load(24'hC00000, 24'h800000, 1'b0);
        check("rs_reload_q",    32'(quotient), 32'h0);
        check("rs_reload_busy", 32'(busy),     32'h1);
        do_shift(N);
        check("rs_quotient", 32'(quotient), 32'hC00000);
        check("rs_sticky",   32'(sticky),   32'h0);
        check("rs_done",     32'(done),     32'h1);

        // Reset during a division beats a simultaneous load and shift.
        do_load(24'h800000, 24'hC00000, 1'b0);
        do_shift(5);
        rst      = 1'b1;
        load     = 1'b1;
        shift_en = 1'b1;
        dividend = 24'hC00000;
        divisor  = 24'h800000;
        tick();
        rst      = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        check("rst_quotient", 32'(quotient), 32'h0);
        check("rst_sticky",   32'(sticky),   32'h0);
        check("rst_done",     32'(done),     32'h0);
        check("rst_busy",     32'(busy),     32'h0);

        // Gap in shift_en with operand inputs changing underneath.
        do_load(24'h800000, 24'hC00000, 1'b0);
        do_shift(12);
        check("gap_pre_q", 32'(quotient), 32'h555);
        dividend = 24'hFFFFFF;
        divisor  = 24'h000001;
        tick();
        tick();
        tick();
        check("gap_hold_q",    32'(quotient), 32'h555);
        check("gap_hold_busy", 32'(busy),     32'h1);
        check("gap_hold_done", 32'(done),     32'h0);
        do_shift(12);
        check("gap_quotient", 32'(quotient), 32'h555555);
        check("gap_sticky",   32'(sticky),   32'h1);
        check("gap_done",     32'(done),     32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mant_div_datapath
`default_nettype wire
